// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus widths, requester count, functional-unit
// slot assignments and the reserved "no producer" label.
package cdb_arbiter_pkg;

    localparam int CDB_NREQ    = 4;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_LABEL_W = 4;

    // Functional-unit slot on the CDB request vector.
    localparam int FU_ALU   = 0;
    localparam int FU_MDU   = 1;
    localparam int FU_LSU   = 2;
    localparam int FU_SPARE = 3;

    // Label 0 never names a producer; an idle CDB carries it.
    localparam int NULL_LABEL = 0;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority picker: returns a one-hot grant for the first set
// request found when scanning from ptr upward, wrapping modulo N.
// Purely combinational so it can also drive reservation-station issue.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    // Scan N slots starting at ptr; the first requester seen wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one finished functional-unit result per
// cycle with rotating priority and broadcasts it on registered CDB outputs
// in the following cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ    = CDB_NREQ,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int LABEL_W = CDB_LABEL_W,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic [NREQ-1:0]           require,
    input  logic [NREQ*DATA_W-1:0]    reqData,
    input  logic [NREQ*LABEL_W-1:0]   reqLabel,
    input  logic                      cdbEnable,
    output logic [NREQ-1:0]           requireAC,
    output logic                      cdbValid,
    output logic [DATA_W-1:0]         cdbData,
    output logic [LABEL_W-1:0]        cdbLabel,
    output logic [IW-1:0]             grantIdx
);

    logic [IW-1:0]      rrPtr;
    logic [NREQ-1:0]    pick_gnt;
    logic               gnt_any;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      ptr_next;
    logic [DATA_W-1:0]  sel_data;
    logic [LABEL_W-1:0] sel_label;

    rr_priority_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (require),
        .ptr   (rrPtr),
        .grant (pick_gnt)
    );

    // No acknowledge while held in reset or while the bus is frozen.
    assign requireAC = (nRST && cdbEnable) ? pick_gnt : '0;
    assign gnt_any   = |requireAC;

    // Encode the one-hot acknowledge and steer the winner's result.
    always_comb begin
        gnt_idx   = '0;
        sel_data  = '0;
        sel_label = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (requireAC[i]) begin
                gnt_idx   = IW'(i);
                sel_data  = reqData[i*DATA_W +: DATA_W];
                sel_label = reqLabel[i*LABEL_W +: LABEL_W];
            end
        end
        ptr_next = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Capture the granted result for a one-cycle broadcast; advance priority past the winner.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cdbValid <= 1'b0;
            cdbData  <= '0;
            cdbLabel <= LABEL_W'(NULL_LABEL);
            grantIdx <= '0;
            rrPtr    <= '0;
        end else if (gnt_any) begin
            cdbValid <= 1'b1;
            cdbData  <= sel_data;
            cdbLabel <= sel_label;
            grantIdx <= gnt_idx;
            rrPtr    <= ptr_next;
        end else begin
            cdbValid <= 1'b0;
            cdbData  <= '0;
            cdbLabel <= LABEL_W'(NULL_LABEL);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NREQ=4, DATA_W=32, LABEL_W=4.
module tb_cdb_arbiter;

    logic         clk;
    logic         nRST;
    logic [3:0]   require;
    logic [127:0] reqData;
    logic [15:0]  reqLabel;
    logic         cdbEnable;
    logic [3:0]   requireAC;
    logic         cdbValid;
    logic [31:0]  cdbData;
    logic [3:0]   cdbLabel;
    logic [1:0]   grantIdx;

    int tests;
    int fails;

    cdb_arbiter dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .reqData   (reqData),
        .reqLabel  (reqLabel),
        .cdbEnable (cdbEnable),
        .requireAC (requireAC),
        .cdbValid  (cdbValid),
        .cdbData   (cdbData),
        .cdbLabel  (cdbLabel),
        .grantIdx  (grantIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit i carries data D000_000i and label 8+i.
    function automatic logic [31:0] exp_data(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] exp_label(input int i);
        return 4'(8 + i);
    endfunction

    task automatic load_defaults();
        for (int i = 0; i < 4; i++) begin
            reqData[i*32 +: 32] = exp_data(i);
            reqLabel[i*4 +: 4]  = exp_label(i);
        end
    endtask

    // Ends at posedge+1 with an idle bus and rrPtr=0.
    task automatic do_reset();
        nRST      = 1'b0;
        require   = 4'b0000;
        cdbEnable = 1'b1;
        load_defaults();
        repeat (2) @(posedge clk);
        #3;
        nRST = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        cdbEnable = 1'b1;
        load_defaults();
        require   = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (requireAC !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ack got=%b want=0000", requireAC);
        end
        tests++;
        if (cdbValid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got=%b want=0", cdbValid);
        end
        tests++;
        if (cdbLabel !== 4'h0 || cdbData !== 32'h0 || grantIdx !== 2'd0) begin
            fails++;
            $display("FAIL reset_regs got label=%h data=%h idx=%0d want 0/0/0",
                     cdbLabel, cdbData, grantIdx);
        end
        nRST = 1'b1;
        #1;
        tests++;
        if (requireAC !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_ack got=%b want=0001", requireAC);
        end
        @(posedge clk);
        #1;
        tests++;
        if (cdbValid !== 1'b1 || cdbLabel !== exp_label(0) || grantIdx !== 2'd0
            || cdbData !== exp_data(0)) begin
            fails++;
            $display("FAIL reset_first_bcast got v=%b label=%h idx=%0d data=%h want 1/%h/0/%h",
                     cdbValid, cdbLabel, grantIdx, cdbData, exp_label(0), exp_data(0));
        end
        require = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        reqData[2*32 +: 32] = 32'h0000_00AA;
        reqLabel[2*4 +: 4]  = 4'h5;
        require = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                #1;
            end else begin
                #1;
            end
            tests++;
            if (requireAC !== 4'b0100) begin
                fails++;
                $display("FAIL single_ack[%0d] got=%b want=0100", k, requireAC);
            end
            @(posedge clk);
            #1;
            if (k == 2) require = 4'b0000;
            tests++;
            if (cdbValid !== 1'b1 || cdbData !== 32'h0000_00AA || cdbLabel !== 4'h5
                || grantIdx !== 2'd2) begin
                fails++;
                $display("FAIL single_bcast[%0d] got v=%b data=%h label=%h idx=%0d want 1/AA/5/2",
                         k, cdbValid, cdbData, cdbLabel, grantIdx);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (cdbValid !== 1'b0 || cdbData !== 32'h0 || cdbLabel !== 4'h0 || grantIdx !== 2'd2) begin
            fails++;
            $display("FAIL single_idle got v=%b data=%h label=%h idx=%0d want 0/0/0/2",
                     cdbValid, cdbData, cdbLabel, grantIdx);
        end
        load_defaults();
    endtask

    task automatic test_contention();
        do_reset();
        require = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++;
            if (requireAC !== (4'b0001 << (k % 4))) begin
                fails++;
                $display("FAIL contend_ack[%0d] got=%b want=%b", k, requireAC, 4'b0001 << (k % 4));
            end
            @(posedge clk);
            #1;
            tests++;
            if (cdbValid !== 1'b1 || grantIdx !== 2'(k % 4) || cdbLabel !== exp_label(k % 4)) begin
                fails++;
                $display("FAIL contend_bcast[%0d] got v=%b idx=%0d label=%h want 1/%0d/%h",
                         k, cdbValid, grantIdx, cdbLabel, k % 4, exp_label(k % 4));
            end
        end
        require = 4'b0000;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        require = 4'b0100;
        @(posedge clk);
        #1;
        tests++;
        if (dut.rrPtr !== 2'd3) begin
            fails++;
            $display("FAIL wrap_setup_ptr got=%0d want=3", dut.rrPtr);
        end
        require = 4'b0110;
        #1;
        tests++;
        if (requireAC !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_first_ack got=%b want=0010", requireAC);
        end
        @(posedge clk);
        #1;
        require = 4'b0100;
        tests++;
        if (grantIdx !== 2'd1 || cdbLabel !== exp_label(1)) begin
            fails++;
            $display("FAIL wrap_first_bcast got idx=%0d label=%h want 1/%h", grantIdx, cdbLabel, exp_label(1));
        end
        #1;
        tests++;
        if (requireAC !== 4'b0100) begin
            fails++;
            $display("FAIL wrap_second_ack got=%b want=0100", requireAC);
        end
        @(posedge clk);
        #1;
        require = 4'b0000;
        tests++;
        if (grantIdx !== 2'd2 || dut.rrPtr !== 2'd3) begin
            fails++;
            $display("FAIL wrap_end got idx=%0d ptr=%0d want 2/3", grantIdx, dut.rrPtr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        require = 4'b0001;
        @(posedge clk);
        #1;
        require   = 4'b0011;
        cdbEnable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (requireAC !== 4'b0000) begin
                fails++;
                $display("FAIL bp_ack[%0d] got=%b want=0000", k, requireAC);
            end
            @(posedge clk);
            #1;
            tests++;
            if (cdbValid !== 1'b0) begin
                fails++;
                $display("FAIL bp_valid[%0d] got=%b want=0", k, cdbValid);
            end
        end
        cdbEnable = 1'b1;
        #1;
        tests++;
        if (requireAC !== 4'b0010) begin
            fails++;
            $display("FAIL bp_resume_ack got=%b want=0010", requireAC);
        end
        @(posedge clk);
        #1;
        require = 4'b0000;
        tests++;
        if (cdbValid !== 1'b1 || grantIdx !== 2'd1 || cdbData !== exp_data(1)) begin
            fails++;
            $display("FAIL bp_resume_bcast got v=%b idx=%0d data=%h want 1/1/%h",
                     cdbValid, grantIdx, cdbData, exp_data(1));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        require = 4'b0010;
        @(posedge clk);
        #1;
        tests++;
        if (cdbValid !== 1'b1 || dut.rrPtr !== 2'd2) begin
            fails++;
            $display("FAIL mid_setup got v=%b ptr=%0d want 1/2", cdbValid, dut.rrPtr);
        end
        #2;
        nRST = 1'b0;
        #1;
        tests++;
        if (cdbValid !== 1'b0 || cdbData !== 32'h0 || cdbLabel !== 4'h0) begin
            fails++;
            $display("FAIL mid_async_drop got v=%b data=%h label=%h want 0/0/0", cdbValid, cdbData, cdbLabel);
        end
        tests++;
        if (requireAC !== 4'b0000) begin
            fails++;
            $display("FAIL mid_ack_in_reset got=%b want=0000", requireAC);
        end
        require = 4'b0000;
        @(posedge clk);
        #3;
        nRST = 1'b1;
        #1;
        tests++;
        if (dut.rrPtr !== 2'd0 || grantIdx !== 2'd0) begin
            fails++;
            $display("FAIL mid_ptr_after got ptr=%0d idx=%0d want 0/0", dut.rrPtr, grantIdx);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        nRST      = 1'b0;
        require   = 4'b0000;
        cdbEnable = 1'b1;
        reqData   = '0;
        reqLabel  = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap_skip();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
